// File: rtl/bp_commit_wb_matcher.sv
// Commit/writeback matcher for the cosimulation path. Committed records wait
// in order until the writeback of their destination register has arrived, then
// leave through a valid/ready port together with the matched writeback data.
module bp_commit_wb_matcher #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int data_width_p  = 64,
    parameter int num_rf_p      = 2,
    parameter int reg_els_p     = 32,
    parameter int cq_els_p      = 16,
    parameter int wb_els_p      = 4,
    parameter int timeout_p     = 1024
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               commit_v_i,
    input  logic [vaddr_width_p-1:0]           commit_pc_i,
    input  logic [instr_width_p-1:0]           commit_instr_i,
    input  logic                               commit_trap_i,
    input  logic [63:0]                        commit_cause_i,
    input  logic [num_rf_p-1:0]                commit_rf_i,
    output logic                               commit_ready_o,
    input  logic [num_rf_p-1:0]                wb_v_i,
    input  logic [num_rf_p*5-1:0]              wb_addr_i,
    input  logic [num_rf_p*data_width_p-1:0]   wb_data_i,
    output logic                               retire_v_o,
    input  logic                               retire_ready_i,
    output logic [vaddr_width_p-1:0]           retire_pc_o,
    output logic [instr_width_p-1:0]           retire_instr_o,
    output logic                               retire_trap_o,
    output logic [63:0]                        retire_cause_o,
    output logic [num_rf_p-1:0]                retire_rf_o,
    output logic [data_width_p-1:0]            retire_data_o,
    output logic [$clog2(cq_els_p+1)-1:0]      pending_o,
    output logic                               overflow_o,
    output logic                               timeout_o
);
    localparam int rd_w   = $clog2(reg_els_p);
    localparam int cq_aw  = $clog2(cq_els_p);
    localparam int wb_aw  = $clog2(wb_els_p);
    localparam int pend_w = $clog2(cq_els_p + 1);
    localparam int to_w   = $clog2(timeout_p + 1);
    localparam int rf_w   = (num_rf_p > 1) ? $clog2(num_rf_p) : 1;

    // Commit queue storage and pointers (one extra pointer bit for full/empty)
    logic [vaddr_width_p-1:0] cq_pc    [cq_els_p];
    logic [instr_width_p-1:0] cq_instr [cq_els_p];
    logic                     cq_trap  [cq_els_p];
    logic [63:0]              cq_cause [cq_els_p];
    logic [num_rf_p-1:0]      cq_rf    [cq_els_p];
    logic [cq_aw:0]           cq_wr, cq_rd;
    logic                     cq_empty, cq_full, cq_push;
    logic [rd_w-1:0]          commit_rd;
    logic [num_rf_p-1:0]      commit_rf;

    // Per-(file, register) writeback FIFOs
    logic [data_width_p-1:0]  wb_mem [num_rf_p][reg_els_p][wb_els_p];
    logic [wb_aw:0]           wb_wr  [num_rf_p][reg_els_p];
    logic [wb_aw:0]           wb_rd  [num_rf_p][reg_els_p];
    logic [rd_w-1:0]          wb_addr [num_rf_p];
    logic [num_rf_p-1:0]      wb_push, wb_drop;

    // Head of the commit queue and its match state
    logic [cq_aw-1:0]         head_idx;
    logic [instr_width_p-1:0] head_instr;
    logic                     head_trap;
    logic [num_rf_p-1:0]      head_rf;
    logic [rd_w-1:0]          head_rd;
    logic [rf_w-1:0]          head_f;
    logic [wb_aw:0]           head_wr, head_rdp;
    logic                     head_needs, head_has_wb, head_ready;
    logic                     pop, wb_pop;

    logic [to_w-1:0]          to_cnt, to_next;
    logic                     overflow, timeout;

    assign cq_empty  = (cq_wr == cq_rd);
    assign cq_full   = (cq_wr[cq_aw] != cq_rd[cq_aw]) &&
                       (cq_wr[cq_aw-1:0] == cq_rd[cq_aw-1:0]);
    assign cq_push   = commit_v_i & ~cq_full;
    assign commit_rd = commit_instr_i[7 +: rd_w];

    // x0 is never written, so an integer-file commit to rd 0 waits on nothing
    always_comb begin
        commit_rf = commit_rf_i;
        if (commit_rd == '0) commit_rf[0] = 1'b0;
    end

    assign head_idx   = cq_rd[cq_aw-1:0];
    assign head_instr = cq_instr[head_idx];
    assign head_trap  = cq_trap[head_idx];
    assign head_rf    = cq_rf[head_idx];
    assign head_rd    = head_instr[7 +: rd_w];

    // The mask is one-hot; its lowest set bit selects the register file
    always_comb begin
        head_f = '0;
        for (int f = num_rf_p - 1; f >= 0; f--) begin
            if (head_rf[f]) head_f = rf_w'(f);
        end
    end

    assign head_wr     = wb_wr[head_f][head_rd];
    assign head_rdp    = wb_rd[head_f][head_rd];
    assign head_needs  = ~head_trap & (|head_rf);
    assign head_has_wb = (head_wr != head_rdp);
    assign head_ready  = ~cq_empty & (~head_needs | head_has_wb);
    assign pop         = head_ready & retire_ready_i;
    assign wb_pop      = pop & head_needs;

    for (genvar f = 0; f < num_rf_p; f++) begin : g_file
        logic           req, full, pop_same;
        logic [wb_aw:0] wp, rp;

        assign wb_addr[f] = wb_addr_i[f*5 +: rd_w];
        assign req        = wb_v_i[f] & ~((f == 0) && (wb_addr[f] == '0));
        assign wp         = wb_wr[f][wb_addr[f]];
        assign rp         = wb_rd[f][wb_addr[f]];
        assign full       = (wp[wb_aw] != rp[wb_aw]) && (wp[wb_aw-1:0] == rp[wb_aw-1:0]);
        // A retire draining this very FIFO makes room for the incoming entry
        assign pop_same   = wb_pop && (head_f == rf_w'(f)) && (head_rd == wb_addr[f]);
        assign wb_push[f] = req & (~full | pop_same);
        assign wb_drop[f] = req & full & ~pop_same;

        for (genvar r = 0; r < reg_els_p; r++) begin : g_reg
            logic push_here, pop_here;

            assign push_here = wb_push[f] && (wb_addr[f] == rd_w'(r));
            assign pop_here  = wb_pop && (head_f == rf_w'(f)) && (head_rd == rd_w'(r));

            // Read/write pointers of this register's writeback FIFO
            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) begin
                    wb_wr[f][r] <= '0;
                    wb_rd[f][r] <= '0;
                end else begin
                    if (push_here) wb_wr[f][r] <= wb_wr[f][r] + 1'b1;
                    if (pop_here)  wb_rd[f][r] <= wb_rd[f][r] + 1'b1;
                end
            end

            // Writeback data lands at the tail slot
            always_ff @(posedge clk_i) begin
                if (push_here)
                    wb_mem[f][r][wb_wr[f][r][wb_aw-1:0]] <= wb_data_i[f*data_width_p +: data_width_p];
            end
        end
    end

    // Commit record fields are written at the queue tail
    always_ff @(posedge clk_i) begin
        if (cq_push) begin
            cq_pc[cq_wr[cq_aw-1:0]]    <= commit_pc_i;
            cq_instr[cq_wr[cq_aw-1:0]] <= commit_instr_i;
            cq_trap[cq_wr[cq_aw-1:0]]  <= commit_trap_i;
            cq_cause[cq_wr[cq_aw-1:0]] <= commit_cause_i;
            cq_rf[cq_wr[cq_aw-1:0]]    <= commit_rf;
        end
    end

    // Stall counter: counts cycles the head waits on a missing writeback
    always_comb begin
        to_next = to_cnt;
        if (cq_empty || pop)
            to_next = '0;
        else if (head_needs && !head_ready && (to_cnt != to_w'(timeout_p)))
            to_next = to_cnt + 1'b1;
    end

    // Queue pointers, stall counter and sticky error flags
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cq_wr    <= '0;
            cq_rd    <= '0;
            to_cnt   <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (cq_push) cq_wr <= cq_wr + 1'b1;
            if (pop)     cq_rd <= cq_rd + 1'b1;
            to_cnt <= to_next;
            if ((commit_v_i & cq_full) | (|wb_drop)) overflow <= 1'b1;
            if (to_next == to_w'(timeout_p)) timeout <= 1'b1;
        end
    end

    assign commit_ready_o = ~cq_full;
    assign pending_o      = pend_w'(cq_wr - cq_rd);
    assign overflow_o     = overflow;
    assign timeout_o      = timeout;
    assign retire_v_o     = head_ready;
    assign retire_pc_o    = cq_empty ? '0 : cq_pc[head_idx];
    assign retire_instr_o = cq_empty ? '0 : head_instr;
    assign retire_trap_o  = cq_empty ? 1'b0 : head_trap;
    assign retire_cause_o = cq_empty ? '0 : cq_cause[head_idx];
    assign retire_rf_o    = cq_empty ? '0 : head_rf;
    assign retire_data_o  = (head_ready & head_needs) ?
                            wb_mem[head_f][head_rd][head_rdp[wb_aw-1:0]] : '0;

endmodule

// File: tb/tb_bp_commit_wb_matcher.sv
// Bench for bp_commit_wb_matcher: directed scenarios plus random traffic,
// every cycle compared against a queue-based model of the matcher.
module tb_bp_commit_wb_matcher;
    localparam int CQ = 16;
    localparam int WB = 4;
    localparam int TO = 1024;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         commit_v_i;
    logic [38:0]  commit_pc_i;
    logic [31:0]  commit_instr_i;
    logic         commit_trap_i;
    logic [63:0]  commit_cause_i;
    logic [1:0]   commit_rf_i;
    logic         commit_ready_o;
    logic [1:0]   wb_v_i;
    logic [9:0]   wb_addr_i;
    logic [127:0] wb_data_i;
    logic         retire_v_o;
    logic         retire_ready_i;
    logic [38:0]  retire_pc_o;
    logic [31:0]  retire_instr_o;
    logic         retire_trap_o;
    logic [63:0]  retire_cause_o;
    logic [1:0]   retire_rf_o;
    logic [63:0]  retire_data_o;
    logic [4:0]   pending_o;
    logic         overflow_o;
    logic         timeout_o;

    always #5 clk_i = ~clk_i;

    bp_commit_wb_matcher dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .commit_v_i(commit_v_i), .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i),
        .commit_trap_i(commit_trap_i), .commit_cause_i(commit_cause_i), .commit_rf_i(commit_rf_i),
        .commit_ready_o(commit_ready_o),
        .wb_v_i(wb_v_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .retire_v_o(retire_v_o), .retire_ready_i(retire_ready_i),
        .retire_pc_o(retire_pc_o), .retire_instr_o(retire_instr_o), .retire_trap_o(retire_trap_o),
        .retire_cause_o(retire_cause_o), .retire_rf_o(retire_rf_o), .retire_data_o(retire_data_o),
        .pending_o(pending_o), .overflow_o(overflow_o), .timeout_o(timeout_o)
    );

    typedef struct {
        logic [38:0] pc;
        logic [31:0] instr;
        logic        trap;
        logic [63:0] cause;
        logic [1:0]  rf;
    } rec_t;

    rec_t        cq[$];
    logic [63:0] wbq [64][$];
    logic        m_ovf, m_to;
    int          m_stall;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_needs(input rec_t r);
        return !r.trap && (r.rf != 2'b00);
    endfunction

    function automatic int m_idx(input rec_t r);
        return (r.rf[0] ? 0 : 32) + int'(r.instr[11:7]);
    endfunction

    function automatic bit m_ready();
        if (cq.size() == 0) return 1'b0;
        if (!m_needs(cq[0])) return 1'b1;
        return wbq[m_idx(cq[0])].size() > 0;
    endfunction

    task automatic model_clear();
        cq.delete();
        for (int i = 0; i < 64; i++) wbq[i].delete();
        m_ovf = 1'b0;
        m_to = 1'b0;
        m_stall = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        bit   was_empty, was_full, pop, stall;
        rec_t r;
        was_empty = (cq.size() == 0);
        was_full = (cq.size() == CQ);
        pop = m_ready() && retire_ready_i;
        stall = !was_empty && m_needs(cq[0]) && !m_ready();
        if (pop) begin
            if (m_needs(cq[0])) void'(wbq[m_idx(cq[0])].pop_front());
            void'(cq.pop_front());
        end
        for (int f = 0; f < 2; f++) begin
            if (wb_v_i[f]) begin
                logic [4:0] a;
                a = wb_addr_i[f*5 +: 5];
                if (!(f == 0 && a == 5'd0)) begin
                    if (wbq[f*32 + int'(a)].size() < WB)
                        wbq[f*32 + int'(a)].push_back(wb_data_i[f*64 +: 64]);
                    else
                        m_ovf = 1'b1;
                end
            end
        end
        if (commit_v_i) begin
            if (was_full) m_ovf = 1'b1;
            else begin
                r.pc = commit_pc_i;
                r.instr = commit_instr_i;
                r.trap = commit_trap_i;
                r.cause = commit_cause_i;
                r.rf = commit_rf_i;
                if (commit_instr_i[11:7] == 5'd0) r.rf[0] = 1'b0;
                cq.push_back(r);
            end
        end
        if (was_empty || pop) m_stall = 0;
        else if (stall && m_stall < TO) m_stall++;
        if (m_stall == TO) m_to = 1'b1;
    endtask

    task automatic check_outputs();
        bit exp_v;
        exp_v = m_ready();
        check("retire_v", 64'(retire_v_o), 64'(exp_v));
        check("commit_ready", 64'(commit_ready_o), 64'(cq.size() < CQ));
        check("pending", 64'(pending_o), 64'(cq.size()));
        check("overflow", 64'(overflow_o), 64'(m_ovf));
        check("timeout", 64'(timeout_o), 64'(m_to));
        if (cq.size() > 0) begin
            check("retire_pc", 64'(retire_pc_o), 64'(cq[0].pc));
            check("retire_instr", 64'(retire_instr_o), 64'(cq[0].instr));
            check("retire_trap", 64'(retire_trap_o), 64'(cq[0].trap));
            check("retire_cause", retire_cause_o, cq[0].cause);
            check("retire_rf", 64'(retire_rf_o), 64'(cq[0].rf));
        end
        if (exp_v)
            check("retire_data", retire_data_o, m_needs(cq[0]) ? wbq[m_idx(cq[0])][0] : 64'd0);
    endtask

    // Called just after a falling edge with inputs set; ends on the next falling edge
    task automatic cycle();
        if (!reset_i) model_clear();
        #1;
        check_outputs();
        @(posedge clk_i);
        if (reset_i) model_step();
        else model_clear();
        @(negedge clk_i);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic idle();
        commit_v_i = 1'b0; commit_pc_i = '0; commit_instr_i = '0; commit_trap_i = 1'b0;
        commit_cause_i = '0; commit_rf_i = '0;
        wb_v_i = '0; wb_addr_i = '0; wb_data_i = '0;
    endtask

    task automatic put_commit(input logic [38:0] pc, input logic [31:0] instr, input logic trap,
                              input logic [63:0] cause, input logic [1:0] rf);
        commit_v_i = 1'b1; commit_pc_i = pc; commit_instr_i = instr;
        commit_trap_i = trap; commit_cause_i = cause; commit_rf_i = rf;
    endtask

    task automatic put_wb(input int f, input logic [4:0] a, input logic [63:0] d);
        wb_v_i[f] = 1'b1;
        wb_addr_i[f*5 +: 5] = a;
        wb_data_i[f*64 +: 64] = d;
    endtask

    task automatic rand_inputs();
        commit_v_i = 1'($urandom_range(0, 1));
        commit_pc_i = {7'($urandom), $urandom};
        commit_instr_i = $urandom & 32'hFFFF_F1FF;
        commit_instr_i[11:7] = 5'($urandom_range(0, 3));
        commit_trap_i = ($urandom_range(0, 9) == 0);
        commit_cause_i = {$urandom, $urandom};
        commit_rf_i = 2'($urandom_range(0, 2));
        wb_v_i = '0;
        for (int f = 0; f < 2; f++)
            if ($urandom_range(0, 9) < 4) put_wb(f, 5'($urandom_range(0, 3)), {$urandom, $urandom});
        retire_ready_i = ($urandom_range(0, 9) < 7);
    endtask

    // Reset is asserted between clock edges; outputs must clear before any edge
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset_i = 1'b0;
            rand_inputs();
            #1;
            check("rst_commit_ready", 64'(commit_ready_o), 64'd1);
            check("rst_retire_v", 64'(retire_v_o), 64'd0);
            check("rst_pending", 64'(pending_o), 64'd0);
            check("rst_flags", 64'({overflow_o, timeout_o}), 64'd0);
            check("rst_fields", 64'({retire_pc_o, retire_instr_o, retire_trap_o, retire_rf_o} != '0), 64'd0);
            check("rst_cause_data", retire_cause_o | retire_data_o, 64'd0);
            cycle();
        end
        reset_i = 1'b1;
        idle();
    endtask

    initial begin
        reset_i = 1'b0;
        retire_ready_i = 1'b0;
        idle();
        model_clear();
        @(negedge clk_i);
        do_reset(4);

        // First commit without a writeback retires one cycle later
        retire_ready_i = 1'b1;
        put_commit(39'h1000, 32'h0000_0013, 1'b0, 64'd0, 2'b00);
        cycle();
        idle();
        #1 check("lat1_retire_v", 64'(retire_v_o), 64'd1);
        cycle();

        // Late writeback to x5
        put_commit(39'h80000000, 32'h0031_02B3, 1'b0, 64'd0, 2'b01);
        cycle();
        idle();
        run(10);
        #1 check("late_wait", 64'(retire_v_o), 64'd0);
        put_wb(0, 5'd5, 64'hDEAD);
        cycle();
        idle();
        #1 check("late_retire_v", 64'(retire_v_o), 64'd1);
        check("late_data", retire_data_o, 64'hDEAD);
        check("late_timeout", 64'(timeout_o), 64'd0);
        cycle();

        // Early writebacks in both files, then fld f3 and addi x3
        put_wb(1, 5'd3, 64'h3FF0_0000_0000_0000);
        put_wb(0, 5'd3, 64'd7);
        cycle();
        idle();
        put_commit(39'h80000004, 32'h0000_B187, 1'b0, 64'd0, 2'b10);
        cycle();
        put_commit(39'h80000008, 32'h0070_0193, 1'b0, 64'd0, 2'b01);
        #1 check("early_fp_data", retire_data_o, 64'h3FF0_0000_0000_0000);
        cycle();
        idle();
        #1 check("early_int_data", retire_data_o, 64'd7);
        cycle();

        // x0 writer, trap, and a writeback to x0
        put_commit(39'h8000000C, 32'h0000_0013, 1'b0, 64'd0, 2'b01);
        put_wb(0, 5'd0, 64'h55);
        cycle();
        idle();
        put_commit(39'h80000010, 32'h0000_0073, 1'b1, 64'd2, 2'b00);
        #1 check("x0_data", retire_data_o, 64'd0);
        check("x0_rf", 64'(retire_rf_o), 64'd0);
        cycle();
        idle();
        #1 check("trap_flag", 64'(retire_trap_o), 64'd1);
        check("trap_cause", retire_cause_o, 64'd2);
        check("trap_data", retire_data_o, 64'd0);
        cycle();
        #1 check("x0_no_overflow", 64'(overflow_o), 64'd0);
        run(2);

        // Writeback FIFO overflow: five writebacks to x7
        do_reset(2);
        retire_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put_wb(0, 5'd7, 64'(i + 1));
            cycle();
        end
        idle();
        #1 check("wb_overflow", 64'(overflow_o), 64'd1);
        cycle();

        // Commit queue overflow: 17 commits with no consumer
        do_reset(2);
        retire_ready_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            put_commit(39'(i * 4), 32'h0000_0013, 1'b0, 64'd0, 2'b00);
            cycle();
        end
        idle();
        #1 check("cq_full_ready", 64'(commit_ready_o), 64'd0);
        check("cq_full_pending", 64'(pending_o), 64'd16);
        check("cq_overflow", 64'(overflow_o), 64'd1);
        retire_ready_i = 1'b1;
        run(18);
        #1 check("cq_overflow_sticky", 64'(overflow_o), 64'd1);

        // Timeout on x9, then backpressure while the writeback arrives
        do_reset(2);
        retire_ready_i = 1'b1;
        put_commit(39'h80000100, 32'h0000_0493, 1'b0, 64'd0, 2'b01);
        cycle();
        idle();
        run(1000);
        #1 check("timeout_early", 64'(timeout_o), 64'd0);
        run(30);
        #1 check("timeout_set", 64'(timeout_o), 64'd1);
        retire_ready_i = 1'b0;
        put_wb(0, 5'd9, 64'h99);
        cycle();
        idle();
        run(3);
        #1 check("hold_v", 64'(retire_v_o), 64'd1);
        check("hold_data", retire_data_o, 64'h99);
        check("hold_pending", 64'(pending_o), 64'd1);
        retire_ready_i = 1'b1;
        cycle();
        #1 check("pop_pending", 64'(pending_o), 64'd0);
        check("timeout_sticky", 64'(timeout_o), 64'd1);
        run(2);

        // Random traffic with a reset in the middle
        do_reset(2);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset(1);
            rand_inputs();
            cycle();
        end
        idle();
        retire_ready_i = 1'b1;
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
